// File: rtl/rr_arb_8_ctrl.sv
// rr_arb_8_ctrl: 8-way round-robin arbiter with registered one-hot grant.
// A grant is held until its owner drops its request. At least one idle cycle
// separates consecutive grants, and the priority pointer then moves to the
// position just past the released owner.
// Optional build macro RR_ARB_TIMEOUT_EN adds the MAX_HOLD parameter, an 8-bit
// hold counter and the tmo port. With the macro, an owner is forcibly released
// after MAX_HOLD consecutive grant cycles.
module rr_arb_8_ctrl
`ifdef RR_ARB_TIMEOUT_EN
#(
   parameter int MAX_HOLD = 15
)
`endif
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] req,
   output logic [7:0] grant,
   output logic [2:0] grant_id,
   output logic       valid
`ifdef RR_ARB_TIMEOUT_EN
   ,
   output logic       tmo
`endif
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state;
   logic [2:0] ptr;
   logic [7:0] rot_req;
   logic [2:0] sel_off;
   logic [2:0] sel_id;
   logic       sel_hit;
   logic       owner_drop;
   logic       release_now;

   // Rotate the request vector so that bit 0 corresponds to the pointer position.
   for (genvar gi = 0; gi < 8; gi++) begin : g_rot
      assign rot_req[gi] = req[3'(ptr + 3'(gi))];
   end

   // Find the lowest set bit of the rotated vector, then map it back to a requester index.
   always_comb begin
      sel_off = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (rot_req[k]) begin
            sel_off = 3'(k);
         end
      end
      sel_id  = 3'(ptr + sel_off);
      sel_hit = |req;
   end

   assign owner_drop = ~req[grant_id];

`ifdef RR_ARB_TIMEOUT_EN
   logic [7:0] hold_cnt;
   logic       hold_done;

   // hold_cnt holds the number of grant cycles already completed. The edge that
   // ends cycle MAX_HOLD therefore sees hold_cnt equal to MAX_HOLD-1.
   assign hold_done   = (hold_cnt == 8'(MAX_HOLD - 1));
   assign release_now = owner_drop | hold_done;
`else
   assign release_now = owner_drop;
`endif

   // Arbitration state machine. All outputs are registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= 3'd0;
         grant    <= 8'd0;
         grant_id <= 3'd0;
         valid    <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
         tmo      <= 1'b0;
         hold_cnt <= 8'd0;
`endif
      end else begin
`ifdef RR_ARB_TIMEOUT_EN
         tmo <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (en && sel_hit) begin
                  state    <= GRANT;
                  grant    <= 8'd1 << sel_id;
                  grant_id <= sel_id;
                  valid    <= 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                  hold_cnt <= 8'd0;
`endif
               end
            end
            GRANT: begin
               if (release_now) begin
                  // Release the grant and move priority past the released owner.
                  state    <= IDLE;
                  grant    <= 8'd0;
                  grant_id <= 3'd0;
                  valid    <= 1'b0;
                  ptr      <= grant_id + 3'd1;
`ifdef RR_ARB_TIMEOUT_EN
                  // Pulse tmo only for a forced release. If the owner drops its
                  // request on the same edge, the release counts as natural.
                  tmo      <= ~owner_drop;
`endif
               end
`ifdef RR_ARB_TIMEOUT_EN
               else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
`endif
            end
         endcase
      end
   end

endmodule
